// File: rtl/pck_injct_scheduler_pkg.sv
// pck_injct_scheduler_pkg: NoC widths, injection packet type and weight helper
// shared by the injection scheduler and its arbiter.
package pck_injct_scheduler_pkg;
    localparam int V          = 2;
    localparam int EAw        = 4;
    localparam int Cw         = 2;
    localparam int PCK_SIZw   = 4;
    localparam int PCK_INJ_Dw = 16;
    localparam int Ww         = 4;
    localparam logic [Ww-1:0] WEIGHT_INIT = 4'd1;

    typedef struct packed {
        logic [PCK_INJ_Dw-1:0] data;
        logic [EAw-1:0]        endp_addr;
        logic [Cw-1:0]         class_num;
        logic [Ww-1:0]         init_weight;
        logic [PCK_SIZw-1:0]   size;
        logic [V-1:0]          vc;
        logic                  pck_wr;
    } pck_injct_t;

    // Initial weight stamped on injected packets for a given NoC configuration.
    function automatic logic [Ww-1:0] conf_weight_init(input int noc_id);
        return (noc_id == 0) ? WEIGHT_INIT : 4'd2;
    endfunction
endpackage

// File: rtl/pck_injct_rr_arbiter.sv
// pck_injct_rr_arbiter: round-robin arbiter with registered pointer.
// Ports: clk, reset (sync, active-low), req[N] requests, gnt_en advances the
// pointer past the winner, gnt[N] one-hot grant, gnt_idx binary winner index.
module pck_injct_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 gnt_en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int Pw = $clog2(N);

    logic [Pw-1:0] ptr_q, ptr_d;
    int            idx;

    // Scanning from the farthest offset back to the pointer leaves the
    // first requester in round-robin order as the final assignment.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[Pw'(idx)]) begin
                gnt     = N'(1) << Pw'(idx);
                gnt_idx = Pw'(idx);
            end
        end
        ptr_d = (gnt_en && |req) ? ((int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/pck_injct_scheduler.sv
// pck_injct_scheduler: shares one injector port among N sources by round-robin,
// gated by VC readiness and per-source token-bucket rate limiting.
// Ports: clk, reset (sync, active-low); req_valid/req_pck per-source requests,
// req_gnt one-hot consume pulse; rate_en/rate_inc token-bucket control;
// inj_ready injector VC readiness; pck_injct_o injector input; sent_cnt
// per-source grant counters; err_bad_req sticky illegal-request flags.
module pck_injct_scheduler
    import pck_injct_scheduler_pkg::*;
#(
    parameter int NOC_ID     = 0,
    parameter int N          = 4,
    parameter int TKw        = 12,
    parameter int BUCKET_MAX = 1024,
    parameter int SCNTw      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               req_valid,
    input  pck_injct_t [N-1:0]         req_pck,
    output logic [N-1:0]               req_gnt,
    input  logic                       rate_en,
    input  logic [N-1:0][TKw-1:0]      rate_inc,
    input  logic [V-1:0]               inj_ready,
    output pck_injct_t                 pck_injct_o,
    output logic [N-1:0][SCNTw-1:0]    sent_cnt,
    output logic [N-1:0]               err_bad_req
);
    localparam logic [TKw:0] BMAX = (TKw + 1)'(BUCKET_MAX);

    logic [N-1:0]            legal, tok_ok, elig;
    logic [N-1:0]            err_q, err_d;
    logic [N-1:0][TKw-1:0]   tokens_q, tokens_d;
    logic [N-1:0][TKw:0]     tok_sum;
    logic [N-1:0][SCNTw-1:0] sent_q, sent_d;
    logic [$clog2(N)-1:0]    gnt_idx;

    // Eligibility is forced low during reset so no grant leaks out.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            legal[i]  = $onehot(req_pck[i].vc) && (req_pck[i].size >= PCK_SIZw'(2));
            tok_ok[i] = !rate_en || (tokens_q[i] >= TKw'(req_pck[i].size));
            elig[i]   = reset && req_valid[i] && legal[i] && tok_ok[i] && |(req_pck[i].vc & inj_ready);
        end
    end

    pck_injct_rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .gnt_en  (reset),
        .gnt     (req_gnt),
        .gnt_idx (gnt_idx)
    );

    // Refill and charge apply together at TKw+1 bits, then saturate.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tok_sum[i]  = {1'b0, tokens_q[i]} + {1'b0, rate_inc[i]}
                        - ((req_gnt[i] && rate_en) ? (TKw + 1)'(req_pck[i].size) : '0);
            tokens_d[i] = (tok_sum[i] > BMAX) ? BMAX[TKw-1:0] : tok_sum[i][TKw-1:0];
            sent_d[i]   = sent_q[i] + SCNTw'(req_gnt[i]);
        end
        err_d       = err_q | (req_valid & ~legal);
        pck_injct_o = '0;
        if (|req_gnt) begin
            pck_injct_o             = req_pck[gnt_idx];
            pck_injct_o.pck_wr      = 1'b1;
            pck_injct_o.init_weight = conf_weight_init(NOC_ID);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tokens_q <= {N{BMAX[TKw-1:0]}};
            sent_q   <= '0;
            err_q    <= '0;
        end else begin
            tokens_q <= tokens_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
        end
    end

    assign sent_cnt    = sent_q;
    assign err_bad_req = err_q;

`ifdef SIMULATION
    always @(posedge clk) begin
        if (pck_injct_o.pck_wr && ~|(pck_injct_o.vc & inj_ready)) begin
            $display("pck_injct_scheduler: packet written to a VC that is not ready");
            $finish;
        end
        if (!$onehot0(req_gnt)) begin
            $display("pck_injct_scheduler: grant vector is not one-hot");
            $finish;
        end
    end
`endif
endmodule

// File: tb/tb_pck_injct_scheduler.sv
// tb_pck_injct_scheduler: randomized self-checking bench against a behavioural model.
module tb_pck_injct_scheduler;
    import pck_injct_scheduler_pkg::*;

    localparam int N     = 4;
    localparam int TKw   = 12;
    localparam int BM    = 16;
    localparam int SCNTw = 32;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [N-1:0]            req_valid = '0;
    pck_injct_t [N-1:0]      req_pck = '0;
    logic [N-1:0]            req_gnt;
    logic                    rate_en = 1'b0;
    logic [N-1:0][TKw-1:0]   rate_inc = '0;
    logic [V-1:0]            inj_ready = '0;
    pck_injct_t              pck_injct_o;
    logic [N-1:0][SCNTw-1:0] sent_cnt;
    logic [N-1:0]            err_bad_req;

    pck_injct_scheduler #(
        .NOC_ID(0), .N(N), .TKw(TKw), .BUCKET_MAX(BM), .SCNTw(SCNTw)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_pck(req_pck),
        .req_gnt(req_gnt), .rate_en(rate_en), .rate_inc(rate_inc),
        .inj_ready(inj_ready), .pck_injct_o(pck_injct_o),
        .sent_cnt(sent_cnt), .err_bad_req(err_bad_req)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what each source's bucket, counter and error
    // flag should hold, plus the rotation start.
    int          m_tok [N];
    int          m_ptr;
    int unsigned m_sent [N];
    logic [N-1:0] m_err;
    logic [N-1:0] exp_gnt;
    pck_injct_t   exp_pck;
    int           exp_g;

    function automatic bit is_legal(input pck_injct_t p);
        return ($countones(p.vc) == 1) && (p.size >= 2);
    endfunction

    function automatic pck_injct_t mk(input logic [V-1:0] vc, input logic [PCK_SIZw-1:0] sz);
        pck_injct_t p;
        p.data        = PCK_INJ_Dw'($urandom);
        p.endp_addr   = EAw'($urandom);
        p.class_num   = Cw'($urandom);
        p.init_weight = Ww'($urandom);
        p.size        = sz;
        p.vc          = vc;
        p.pck_wr      = 1'($urandom);
        return p;
    endfunction

    function automatic logic [V-1:0] rand_vc1();
        return V'(1) << $urandom_range(V - 1);
    endfunction

    task automatic model_eval();
        exp_gnt = '0;
        exp_pck = '0;
        exp_g   = -1;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (exp_g < 0 && req_valid[i] && is_legal(req_pck[i]) &&
                    (!rate_en || m_tok[i] >= int'(req_pck[i].size)) &&
                    ((req_pck[i].vc & inj_ready) != 0))
                    exp_g = i;
            end
        end
        if (exp_g >= 0) begin
            exp_gnt[exp_g]      = 1'b1;
            exp_pck             = req_pck[exp_g];
            exp_pck.pck_wr      = 1'b1;
            exp_pck.init_weight = WEIGHT_INIT;
        end
    endtask

    task automatic model_commit();
        if (!reset) begin
            m_ptr = 0;
            m_err = '0;
            for (int i = 0; i < N; i++) begin
                m_tok[i]  = BM;
                m_sent[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                int t;
                if (req_valid[i] && !is_legal(req_pck[i])) m_err[i] = 1'b1;
                t = m_tok[i] + int'(rate_inc[i]) - ((i == exp_g && rate_en) ? int'(req_pck[i].size) : 0);
                m_tok[i] = (t > BM) ? BM : t;
                if (i == exp_g) m_sent[i]++;
            end
            if (exp_g >= 0) m_ptr = (exp_g + 1) % N;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = N'($urandom);
            inj_ready = V'($urandom);
            for (int i = 0; i < N; i++) req_pck[i] = mk(rand_vc1(), 4'd2);
            settle();
            n_cmp++;
            if (req_gnt !== '0) begin n_bad++; $display("FAIL reset_gnt c%0d: got %b want 0", c, req_gnt); end
            n_cmp++;
            if (pck_injct_o !== '0) begin n_bad++; $display("FAIL reset_pck c%0d: got %h want 0", c, pck_injct_o); end
            if (c > 0) begin
                n_cmp++;
                if (sent_cnt !== '0 || err_bad_req !== '0) begin
                    n_bad++; $display("FAIL reset_state c%0d: sent %h err %b want 0", c, sent_cnt, err_bad_req);
                end
            end
            advance();
        end
    endtask

    task automatic test_rr();
        reset = 1'b1; rate_en = 1'b0; inj_ready = '1; rate_inc = '0; req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) req_pck[i] = mk(rand_vc1(), 4'd2);
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt || req_gnt !== (N'(1) << (c % N))) begin
                n_bad++; $display("FAIL rr_gnt c%0d: got %b want %b", c, req_gnt, N'(1) << (c % N));
            end
            n_cmp++;
            if (pck_injct_o !== exp_pck) begin n_bad++; $display("FAIL rr_pck c%0d: got %h want %h", c, pck_injct_o, exp_pck); end
            advance();
        end
        req_valid = '0;
        settle();
        n_cmp++;
        if (sent_cnt[0] !== 2 || sent_cnt[1] !== 1 || sent_cnt[2] !== 1 || sent_cnt[3] !== 1) begin
            n_bad++; $display("FAIL rr_sent: got %h want {1,1,1,2}", sent_cnt);
        end
        advance();
    endtask

    task automatic test_vc_block();
        req_valid = 4'b0011;
        req_pck[0] = mk(2'b01, 4'd3);
        req_pck[1] = mk(2'b10, 4'd3);
        inj_ready = 2'b10;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) inj_ready = 2'b11;
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt || req_gnt !== ((c == 3) ? 4'b0001 : 4'b0010)) begin
                n_bad++; $display("FAIL vc_gnt c%0d: got %b model %b", c, req_gnt, exp_gnt);
            end
            n_cmp++;
            if (pck_injct_o !== exp_pck) begin n_bad++; $display("FAIL vc_pck c%0d: got %h want %h", c, pck_injct_o, exp_pck); end
            advance();
            req_pck[1] = mk(2'b10, 4'd3);
        end
        req_valid = '0;
    endtask

    task automatic test_rate();
        rate_en = 1'b1; inj_ready = '1; rate_inc = '0; rate_inc[0] = 1;
        req_valid = 4'b0001;
        for (int c = 0; c < 17; c++) begin
            bit want;
            req_pck[0] = mk(2'b01, 4'd8);
            want = (c == 0 || c == 1 || c == 8 || c == 16);
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt || req_gnt[0] !== want) begin
                n_bad++; $display("FAIL rate_gnt c%0d: got %b want %b", c, req_gnt[0], want);
            end
            advance();
        end
        req_valid = '0;
    endtask

    task automatic test_saturation();
        rate_en = 1'b1; req_valid = '0;
        for (int i = 0; i < N; i++) rate_inc[i] = BM;
        for (int c = 0; c < 10; c++) begin
            settle();
            n_cmp++;
            if (req_gnt !== '0) begin n_bad++; $display("FAIL sat_idle c%0d: got %b want 0", c, req_gnt); end
            advance();
        end
        rate_inc = '0; req_valid = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            req_pck[0] = mk(2'b01, 4'd8);
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt || req_gnt[0] !== (c < 2)) begin
                n_bad++; $display("FAIL sat_gnt c%0d: got %b want %b", c, req_gnt[0], c < 2);
            end
            advance();
        end
        req_valid = '0;
    endtask

    task automatic test_illegal();
        rate_en = 1'b0; inj_ready = '1; req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) req_pck[i] = mk(rand_vc1(), 4'($urandom_range(2, 15)));
            req_pck[2] = (c < 6) ? mk(2'b11, 4'd4) : (c < 10) ? mk(2'b01, 4'd1) : mk(2'b01, 4'd4);
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt || (c < 10 && req_gnt[2] !== 1'b0)) begin
                n_bad++; $display("FAIL ill_gnt c%0d: got %b want %b", c, req_gnt, exp_gnt);
            end
            n_cmp++;
            if (err_bad_req !== m_err) begin n_bad++; $display("FAIL ill_err c%0d: got %b want %b", c, err_bad_req, m_err); end
            advance();
        end
        settle();
        n_cmp++;
        if (err_bad_req !== 4'b0100) begin n_bad++; $display("FAIL ill_sticky: got %b want 0100", err_bad_req); end
        advance();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        rate_en = 1'b0; inj_ready = '1; req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) req_pck[i] = mk(rand_vc1(), 4'd2);
            reset = (c != 3);
            if (c == 4) req_valid = 4'b1110;
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt || (c == 3 && req_gnt !== '0) || (c == 4 && req_gnt !== 4'b0010)) begin
                n_bad++; $display("FAIL rstm_gnt c%0d: got %b want %b", c, req_gnt, exp_gnt);
            end
            n_cmp++;
            if (pck_injct_o !== exp_pck || (c == 3 && pck_injct_o.pck_wr !== 1'b0)) begin
                n_bad++; $display("FAIL rstm_pck c%0d: got %h want %h", c, pck_injct_o, exp_pck);
            end
            if (c == 4) begin
                n_cmp++;
                if (sent_cnt !== '0 || err_bad_req !== '0) begin
                    n_bad++; $display("FAIL rstm_state: sent %h err %b want 0", sent_cnt, err_bad_req);
                end
            end
            advance();
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(49) != 0);
            rate_en   = 1'($urandom);
            inj_ready = V'($urandom);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                rate_inc[i] = TKw'($urandom_range(5));
                req_pck[i]  = ($urandom_range(7) == 0) ? mk(V'($urandom), 4'($urandom))
                                                       : mk(rand_vc1(), 4'($urandom_range(2, 15)));
            end
            settle();
            n_cmp++;
            if (req_gnt !== exp_gnt) begin n_bad++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, req_gnt, exp_gnt); end
            n_cmp++;
            if (pck_injct_o !== exp_pck) begin n_bad++; $display("FAIL rnd_pck c%0d: got %h want %h", c, pck_injct_o, exp_pck); end
            n_cmp++;
            if (err_bad_req !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_bad_req, m_err); end
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (sent_cnt[i] !== m_sent[i]) begin
                    n_bad++; $display("FAIL rnd_sent%0d c%0d: got %0d want %0d", i, c, sent_cnt[i], m_sent[i]);
                end
            end
            advance();
        end
        reset = 1'b1;
    endtask

    initial begin
        model_commit();
        #1;
        test_reset();
        test_rr();
        test_vc_block();
        test_rate();
        test_saturation();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
